pipelined_wallace_mult: RTL and testbench
=========================================

PIPELINED_WALLACE_MULT -- requirements
Module: pipelined_wallace_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand width in bits; the legal range is 4..32.
REQ-002 SHALL have parameter SIGNED, default 0, meaning operand format: 0 = unsigned, 1 = two's complement (Baugh-Wooley).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: a and b are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: the multiplicand.
REQ-008 SHALL have port b, input, WIDTH bits: the multiplier.
REQ-009 SHALL have port out_valid, output, 1 bit: product holds a valid result.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts product this cycle.
REQ-011 SHALL have port product, output, 2*WIDTH bits: the result of a*b.

Function
REQ-012 SHALL transfer an input only when in_valid && in_ready, and an output only when out_valid && out_ready.
REQ-013 SHALL form WIDTH partial-product rows combinationally; for SIGNED=1 it SHALL invert the MSB-row/column terms and add the correction constants per Baugh-Wooley.
REQ-014 SHALL reduce the rows to two rows (sum, carry) with a Wallace tree of 3:2 and 2:2 compressors, all at 2*WIDTH width with carries out of bit 2*WIDTH-1 discarded.
REQ-015 Stage 1 SHALL register the sum row, the carry row and the s1_valid flag on an accepted input.
REQ-016 Stage 2 SHALL register the final carry-propagate sum (sum + carry, modulo 2^(2*WIDTH)) into product and set out_valid.
REQ-017 SHALL have a latency of exactly 2 cycles from input acceptance to out_valid when out_ready is held high.
REQ-018 SHALL accept one input per cycle under sustained in_valid with out_ready=1.
REQ-019 SHALL define s2_accept = !out_valid || out_ready and in_ready = !s1_valid || s2_accept; in_ready SHALL have no combinational dependence on in_valid.
REQ-020 SHALL hold product and out_valid stable while out_valid && !out_ready, and SHALL hold the stage-1 contents when stage 1 cannot advance.
REQ-021 When both stages are full and out_ready=0, SHALL deassert in_ready and lose no data.
REQ-022 When out_ready=1 and the pipeline is full, SHALL shift both stages and accept a new input in the same cycle.
REQ-023 SHALL clear s1_valid when stage 1 advances with no new input accepted.
REQ-024 SHALL clear out_valid on output acceptance with no stage-1 data advancing.
REQ-025 Results SHALL emerge in acceptance order.

Reset
REQ-026 rst_n=0 SHALL immediately clear s1_valid and out_valid, and set product and the stage-1 rows to 0, regardless of clk.
REQ-027 In-flight operands at reset assertion SHALL be discarded; no output may appear for them after reset.
REQ-028 in_ready SHALL be 1 during and after reset, since the pipeline is empty.
REQ-029 The first capture SHALL occur on the first rising clk edge with rst_n=1.

Structure
REQ-030 Shared package wallace_pkg SHALL hold WIDTH_MIN/WIDTH_MAX limits and the Baugh-Wooley correction-constant function.
REQ-031 The compressor sub-module SHALL be full_adder (outputs sum, cout; inputs a, b, cin); 2:2 cells SHALL reuse the existing half_adder.
REQ-032 The tree SHALL be generated by parameter-driven generate loops with no hand-instantiated per-width netlists.
REQ-033 Only the stage-1 and stage-2 registers SHALL be sequential; an elaboration check SHALL reject WIDTH outside 4..32.

Verification
REQ-034 WIDTH=8, SIGNED=0: a=255, b=255, out_ready=1 -> product=16'hFE01 with out_valid exactly 2 cycles after acceptance.
REQ-035 WIDTH=8, SIGNED=1: (a,b) = (-128,-128), (-1,1), (127,-128) back-to-back -> 16'h4000, 16'hFFFF, 16'hC080 on three consecutive cycles.
REQ-036 Backpressure: 3 inputs (2×3, 4×5, 6×7), out_ready=0 for 5 cycles -> in_ready drops after 2 acceptances, product holds 6; release -> 6, 20, 42 delivered in order.
REQ-037 Reset mid-flight: accept 9×9, assert rst_n low one cycle later -> out_valid=0 and product=0 immediately; no 81 ever appears.
REQ-038 WIDTH=16 and WIDTH=4: 10k random pairs with random valid/ready stalls, checked against a behavioural a*b model -> zero mismatches, no drops or duplicates.

Source files
------------

// File: rtl/wallace_pkg.sv
// Shared limits and helpers for the pipelined Wallace-tree multiplier.
// Row-count helpers let the tree generator size each reduction level at elaboration.
package wallace_pkg;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 32;

    // Baugh-Wooley constant: +2^W and +2^(2W-1), taken modulo 2^(2W).
    function automatic logic [63:0] bw_correction(input int width);
        return (64'd1 << width) | (64'd1 << (2 * width - 1));
    endfunction

    function automatic int rows_next(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int rows_at(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) begin
            r = rows_next(r);
        end
        return r;
    endfunction

    function automatic int tree_levels(input int n);
        int r;
        int c;
        r = n;
        c = 0;
        while (r > 2) begin
            r = rows_next(r);
            c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/full_adder.sv
// 3:2 compressor cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/half_adder.sv
// 2:2 compressor cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

// File: rtl/pipelined_wallace_mult_tree.sv
// Combinational partial-product generation and Wallace reduction to a sum/carry pair.
// Every level works at 2*WIDTH bits; carries out of the top bit are dropped.
module pipelined_wallace_mult_tree
    import wallace_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] sum_o,
    output logic [2*WIDTH-1:0] carry_o
);
    localparam int PW    = 2 * WIDTH;
    localparam int NROWS = WIDTH + (SIGNED ? 1 : 0);
    localparam int NLEV  = tree_levels(NROWS);
    localparam logic [63:0] CORR64 = bw_correction(WIDTH);

    logic [PW-1:0] pp_rows [NROWS];

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        logic [WIDTH-1:0] pp;
        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            // Terms mixing exactly one sign bit are inverted in signed mode.
            if (SIGNED && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin : g_inv
                assign pp[j] = ~(a_i[j] & b_i[i]);
            end else begin : g_pos
                assign pp[j] = a_i[j] & b_i[i];
            end
        end
        assign pp_rows[i] = {{WIDTH{1'b0}}, pp} << i;
    end

    if (SIGNED) begin : g_corr
        assign pp_rows[WIDTH] = CORR64[PW-1:0];
    end

    for (genvar k = 0; k < NLEV; k++) begin : g_lvl
        localparam int N  = rows_at(NROWS, k);
        localparam int G  = N / 3;
        localparam int L  = N % 3;
        localparam int NN = rows_next(N);

        logic [PW-1:0] cur [N];
        logic [PW-1:0] nxt [NN];

        if (k == 0) begin : g_first
            assign cur = pp_rows;
        end else begin : g_chain
            assign cur = g_lvl[k-1].nxt;
        end

        for (genvar g = 0; g < G; g++) begin : g_fa
            logic [PW-1:0] s;
            logic [PW-2:0] c;
            for (genvar j = 0; j < PW - 1; j++) begin : g_col
                full_adder u_fa (
                    .a   (cur[3*g][j]),
                    .b   (cur[3*g+1][j]),
                    .cin (cur[3*g+2][j]),
                    .sum (s[j]),
                    .cout(c[j])
                );
            end
            assign s[PW-1]     = cur[3*g][PW-1] ^ cur[3*g+1][PW-1] ^ cur[3*g+2][PW-1];
            assign nxt[2*g]    = s;
            assign nxt[2*g+1]  = {c, 1'b0};
        end

        if (L == 1) begin : g_pass
            assign nxt[2*G] = cur[3*G];
        end else if (L == 2) begin : g_ha
            logic [PW-1:0] s;
            logic [PW-2:0] c;
            for (genvar j = 0; j < PW - 1; j++) begin : g_col
                half_adder u_ha (
                    .a   (cur[3*G][j]),
                    .b   (cur[3*G+1][j]),
                    .sum (s[j]),
                    .cout(c[j])
                );
            end
            assign s[PW-1]      = cur[3*G][PW-1] ^ cur[3*G+1][PW-1];
            assign nxt[2*G]     = s;
            assign nxt[2*G+1]   = {c, 1'b0};
        end
    end

    assign sum_o   = g_lvl[NLEV-1].nxt[0];
    assign carry_o = g_lvl[NLEV-1].nxt[1];

endmodule

// File: rtl/pipelined_wallace_mult.sv
// Two-stage valid/ready Wallace-tree multiplier: stage 1 holds the reduced
// sum/carry rows, stage 2 holds the carry-propagated product.
module pipelined_wallace_mult
    import wallace_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);
    localparam int PW = 2 * WIDTH;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("pipelined_wallace_mult: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    logic [PW-1:0] tree_sum;
    logic [PW-1:0] tree_carry;

    logic          s1_valid_q, s1_valid_d;
    logic [PW-1:0] s1_sum_q, s1_sum_d;
    logic [PW-1:0] s1_carry_q, s1_carry_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] product_q, product_d;
    logic          s2_accept;

    pipelined_wallace_mult_tree #(
        .WIDTH (WIDTH),
        .SIGNED(SIGNED)
    ) u_tree (
        .a_i    (a),
        .b_i    (b),
        .sum_o  (tree_sum),
        .carry_o(tree_carry)
    );

    // Ready depends only on registered state, never on in_valid.
    assign s2_accept = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_accept;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_carry_d  = s1_carry_q;
        out_valid_d = out_valid_q;
        product_d   = product_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sum_d   = tree_sum;
                s1_carry_d = tree_carry;
            end
        end

        if (s2_accept) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                product_d = s1_sum_q + s1_carry_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_carry_q  <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_carry_q  <= s1_carry_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
        end
    end

    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_pipelined_wallace_mult.sv
// Scoreboard bench for pipelined_wallace_mult across four width/sign configurations.
module tb_pipelined_wallace_mult;

    localparam int NDUT = 4;
    localparam int W_CFG [NDUT] = '{8, 8, 16, 4};
    localparam bit S_CFG [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv_s   [NDUT];
    logic        ir_s   [NDUT];
    logic        ov_s   [NDUT];
    logic        ordy_s [NDUT];
    logic [31:0] a_s    [NDUT];
    logic [31:0] b_s    [NDUT];
    logic [63:0] p_s    [NDUT];

    logic [63:0] sb [NDUT][$];
    bit          stall_q [NDUT];
    logic [63:0] held_p  [NDUT];
    int          acc_cnt [NDUT];

    int n_chk  = 0;
    int n_pass = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = W_CFG[g];
        logic [2*W-1:0] p;
        pipelined_wallace_mult #(
            .WIDTH (W),
            .SIGNED(S_CFG[g])
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (iv_s[g]),
            .in_ready (ir_s[g]),
            .a        (a_s[g][W-1:0]),
            .b        (b_s[g][W-1:0]),
            .out_valid(ov_s[g]),
            .out_ready(ordy_s[g]),
            .product  (p)
        );
        assign p_s[g] = 64'(p);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [63:0] model(input int k, input logic [31:0] av, input logic [31:0] bv);
        int          w;
        logic [63:0] x;
        logic [63:0] y;
        w = W_CFG[k];
        x = {32'b0, av} & ((64'd1 << w) - 64'd1);
        y = {32'b0, bv} & ((64'd1 << w) - 64'd1);
        if (S_CFG[k]) begin
            x = $signed(x << (64 - w)) >>> (64 - w);
            y = $signed(y << (64 - w)) >>> (64 - w);
        end
        return (x * y) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [31:0] pick(input int k);
        int w;
        w = W_CFG[k];
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd1 << (w - 1);
            default: return $urandom;
        endcase
    endfunction

    // One clock cycle on DUT k: drive at negedge, then sample the handshakes
    // that the next rising edge will perform.
    task automatic step(input int k, input logic iv, input logic [31:0] av,
                        input logic [31:0] bv, input logic ordy);
        @(negedge clk);
        iv_s[k]   = iv;
        a_s[k]    = av;
        b_s[k]    = bv;
        ordy_s[k] = ordy;
        #1;
        if (stall_q[k]) begin
            chk("hold_valid", 64'(ov_s[k]), 64'd1);
            chk("hold_product", p_s[k], held_p[k]);
        end
        stall_q[k] = ov_s[k] && !ordy;
        held_p[k]  = p_s[k];
        if (ov_s[k] && ordy) begin
            if (sb[k].size() == 0) chk("spurious_out", 64'(ov_s[k]), 64'd0);
            else chk("product", p_s[k], sb[k].pop_front());
        end
        if (iv && ir_s[k]) begin
            sb[k].push_back(model(k, av, bv));
            acc_cnt[k]++;
        end
    endtask

    task automatic drain(input int k);
        int guard;
        guard = 0;
        while (sb[k].size() != 0 && guard < 100) begin
            step(k, 1'b0, 32'd0, 32'd0, 1'b1);
            guard++;
        end
        chk("drain_empty", 64'(sb[k].size()), 64'd0);
    endtask

    task automatic run_random(input int k, input int n);
        int cyc;
        cyc = 0;
        acc_cnt[k] = 0;
        while (acc_cnt[k] < n && cyc < 4 * n) begin
            step(k, $urandom_range(0, 3) != 0, pick(k), pick(k), $urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("rand_accepted", 64'(acc_cnt[k]), 64'(n));
        drain(k);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        for (int k = 0; k < NDUT; k++) begin
            iv_s[k]    = 1'b0;
            ordy_s[k]  = 1'b1;
            a_s[k]     = '0;
            b_s[k]     = '0;
            stall_q[k] = 1'b0;
            held_p[k]  = '0;
            acc_cnt[k] = 0;
        end

        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_in_ready", 64'(ir_s[k]), 64'd1);
            chk("rst_out_valid", 64'(ov_s[k]), 64'd0);
            chk("rst_product", p_s[k], 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned 255*255 latency
        step(0, 1'b1, 32'd255, 32'd255, 1'b1);
        step(0, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("lat_c1_valid", 64'(ov_s[0]), 64'd0);
        step(0, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("lat_c2_valid", 64'(ov_s[0]), 64'd1);
        chk("lat_c2_product", p_s[0], 64'hFE01);
        drain(0);

        // Signed back-to-back
        step(1, 1'b1, 32'h80, 32'h80, 1'b1);
        step(1, 1'b1, 32'hFF, 32'h01, 1'b1);
        step(1, 1'b1, 32'h7F, 32'h80, 1'b1);
        chk("sgn_v0", 64'(ov_s[1]), 64'd1);
        chk("sgn_p0", p_s[1], 64'h4000);
        step(1, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("sgn_v1", 64'(ov_s[1]), 64'd1);
        chk("sgn_p1", p_s[1], 64'hFFFF);
        step(1, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("sgn_v2", 64'(ov_s[1]), 64'd1);
        chk("sgn_p2", p_s[1], 64'hC080);
        drain(1);

        // Backpressure: five cycles with out_ready low
        base = acc_cnt[0];
        step(0, 1'b1, 32'd2, 32'd3, 1'b0);
        step(0, 1'b1, 32'd4, 32'd5, 1'b0);
        step(0, 1'b1, 32'd6, 32'd7, 1'b0);
        chk("bp_in_ready", 64'(ir_s[0]), 64'd0);
        chk("bp_accepted", 64'(acc_cnt[0] - base), 64'd2);
        step(0, 1'b1, 32'd6, 32'd7, 1'b0);
        step(0, 1'b1, 32'd6, 32'd7, 1'b0);
        chk("bp_hold_in_ready", 64'(ir_s[0]), 64'd0);
        chk("bp_hold_valid", 64'(ov_s[0]), 64'd1);
        chk("bp_hold_product", p_s[0], 64'd6);
        step(0, 1'b1, 32'd6, 32'd7, 1'b1);
        chk("bp_release_accepted", 64'(acc_cnt[0] - base), 64'd3);
        drain(0);

        // Reset with 9*9 in flight
        step(0, 1'b1, 32'd9, 32'd9, 1'b1);
        step(0, 1'b0, 32'd0, 32'd0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(ov_s[0]), 64'd0);
        chk("mid_rst_product", p_s[0], 64'd0);
        chk("mid_rst_in_ready", 64'(ir_s[0]), 64'd1);
        for (int k = 0; k < NDUT; k++) begin
            sb[k].delete();
            stall_q[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("mid_rst_held_valid", 64'(ov_s[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b0, 32'd0, 32'd0, 1'b1);
            chk("no_ghost_valid", 64'(ov_s[0]), 64'd0);
            chk("no_ghost_product", p_s[0], 64'd0);
        end

        // Random traffic with stalls
        run_random(0, 300);
        run_random(1, 300);
        run_random(2, 10000);
        run_random(3, 10000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
